pep_batch_former: RTL and testbench

// - Sits upstream of the pe_pbs processing pipe; consumes the batch geometry (BATCH_PBS_NB, TOTAL_PBS_NB, TOTAL_BATCH_NB).
// - Allocates a free PBS slot id (pid) per incoming PBS request and groups accepted pids into batches of <= BATCH_PBS_NB.
// - Issues each batch as a pid mask to the pipe; recycles pids released by the pipe.

---
 rtl/pep_batch_former_pkg.sv | 21 ++
 rtl/pep_batch_former_if.sv | 33 +++
 rtl/pep_batch_former_pid_pool.sv | 62 ++++++
 rtl/pep_batch_former.sv | 117 +++++++++++
 tb/tb_pep_batch_former.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pep_batch_former_pkg.sv
// Shared geometry defaults, derived widths and types for the PBS batch former.
package pep_batch_former_pkg;

    localparam int DEF_TOTAL_PBS_NB   = 32;
    localparam int DEF_BATCH_PBS_NB   = 16;
    localparam int DEF_TOTAL_BATCH_NB = 1;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    localparam int PID_W = $clog2(DEF_TOTAL_PBS_NB);
    localparam int CNT_W = $clog2(DEF_BATCH_PBS_NB + 1);

    typedef logic [PID_W-1:0]            pid_t;
    typedef logic [DEF_TOTAL_PBS_NB-1:0] pid_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE
    } state_e;

endpackage

// File: rtl/pep_batch_former_if.sv
// Request, batch-command and pid-release signals between the batch former and its neighbours.
interface pep_batch_former_if #(
    parameter int TOTAL_PBS_NB = 32,
    parameter int BATCH_PBS_NB = 16
);
    localparam int PID_W  = $clog2(TOTAL_PBS_NB);
    localparam int CNT_W  = $clog2(BATCH_PBS_NB + 1);
    localparam int FCNT_W = $clog2(TOTAL_PBS_NB + 1);

    logic                    in_vld;
    logic                    in_rdy;
    logic [PID_W-1:0]        in_pid;
    logic                    flush;
    logic                    bcmd_vld;
    logic                    bcmd_rdy;
    logic [TOTAL_PBS_NB-1:0] bcmd_pid_mask;
    logic [CNT_W-1:0]        bcmd_pbs_nb;
    logic                    bdone;
    logic                    free_vld;
    logic [PID_W-1:0]        free_pid;
    logic [FCNT_W-1:0]       free_cnt;

    modport master (
        output in_vld, flush, bcmd_rdy, bdone, free_vld, free_pid,
        input  in_rdy, in_pid, bcmd_vld, bcmd_pid_mask, bcmd_pbs_nb, free_cnt
    );

    modport slave (
        input  in_vld, flush, bcmd_rdy, bdone, free_vld, free_pid,
        output in_rdy, in_pid, bcmd_vld, bcmd_pid_mask, bcmd_pbs_nb, free_cnt
    );

endinterface

// File: rtl/pep_batch_former_pid_pool.sv
// Free-pid pool: lowest-free priority allocation, release, and registered free count.
module pep_batch_former_pid_pool
    import pep_batch_former_pkg::*;
#(
    parameter int TOTAL_PBS_NB = DEF_TOTAL_PBS_NB
) (
    input  logic                              clk,
    input  logic                              s_rst,
    input  logic                              alloc_i,
    input  logic                              free_vld_i,
    input  logic [$clog2(TOTAL_PBS_NB)-1:0]   free_pid_i,
    output logic [$clog2(TOTAL_PBS_NB)-1:0]   alloc_pid_o,
    output logic [$clog2(TOTAL_PBS_NB+1)-1:0] free_cnt_o,
    output logic                              empty_next_o
);
    localparam int P_W    = $clog2(TOTAL_PBS_NB);
    localparam int FCNT_W = $clog2(TOTAL_PBS_NB + 1);

    logic [TOTAL_PBS_NB-1:0] free_mask_q, free_mask_d;
    logic [FCNT_W-1:0]       free_cnt_q, free_cnt_d;
    logic                    release_ok;

    // A release of a pid that is already free is dropped so the count cannot drift.
    assign release_ok = free_vld_i & ~free_mask_q[free_pid_i];

    always_comb begin
        alloc_pid_o = '0;
        for (int i = TOTAL_PBS_NB - 1; i >= 0; i--) begin
            if (free_mask_q[i]) alloc_pid_o = P_W'(i);
        end
    end

    genvar gi;
    for (gi = 0; gi < TOTAL_PBS_NB; gi++) begin : g_mask
        assign free_mask_d[gi] = (free_mask_q[gi] & ~(alloc_i && (alloc_pid_o == P_W'(gi))))
                               | (release_ok && (free_pid_i == P_W'(gi)));
    end

    assign free_cnt_d   = free_cnt_q - FCNT_W'(alloc_i) + FCNT_W'(release_ok);
    assign empty_next_o = (free_cnt_d == '0);
    assign free_cnt_o   = free_cnt_q;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            free_mask_q <= '1;
            free_cnt_q  <= FCNT_W'(TOTAL_PBS_NB);
        end else begin
            free_mask_q <= free_mask_d;
            free_cnt_q  <= free_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst && free_vld_i) begin
            assert (!free_mask_q[free_pid_i]) else $error("pid pool: release of already-free pid");
        end
        if (!s_rst && alloc_i) begin
            assert (free_cnt_q != '0) else $error("pid pool: allocation from empty pool");
        end
    end

endmodule

// File: rtl/pep_batch_former.sv
// Groups allocated pids into batches and issues each as a pid mask, bounded by batches in flight.
module pep_batch_former
    import pep_batch_former_pkg::*;
#(
    parameter int TOTAL_PBS_NB   = DEF_TOTAL_PBS_NB,
    parameter int BATCH_PBS_NB   = DEF_BATCH_PBS_NB,
    parameter int TOTAL_BATCH_NB = DEF_TOTAL_BATCH_NB,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              s_rst,
    pep_batch_former_if.slave pep_if
);
    localparam int P_W   = $clog2(TOTAL_PBS_NB);
    localparam int C_W   = $clog2(BATCH_PBS_NB + 1);
    localparam int IF_W  = $clog2(TOTAL_BATCH_NB + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [C_W-1:0]   BATCH_C  = C_W'(BATCH_PBS_NB);
    localparam logic [IF_W-1:0]  INFL_MAX = IF_W'(TOTAL_BATCH_NB);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [C_W-1:0]          count_q, count_d, count_post;
    logic [TOTAL_PBS_NB-1:0] mask_q, mask_d, mask_post, pid_onehot;
    logic [TMR_W-1:0]        timer_q, timer_d, timer_post;
    logic [IF_W-1:0]         inflight_q, inflight_d;
    logic                    in_rdy, accept, bcmd_vld, hs, bdone_ok, close, empty_next;
    logic [P_W-1:0]          alloc_pid;

    pep_batch_former_pid_pool #(
        .TOTAL_PBS_NB (TOTAL_PBS_NB)
    ) u_pool (
        .clk          (clk),
        .s_rst        (s_rst),
        .alloc_i      (accept),
        .free_vld_i   (pep_if.free_vld),
        .free_pid_i   (pep_if.free_pid),
        .alloc_pid_o  (alloc_pid),
        .free_cnt_o   (pep_if.free_cnt),
        .empty_next_o (empty_next)
    );

    genvar gi;
    for (gi = 0; gi < TOTAL_PBS_NB; gi++) begin : g_onehot
        assign pid_onehot[gi] = (alloc_pid == P_W'(gi));
    end

    assign in_rdy   = (state_q != ST_ISSUE) && (pep_if.free_cnt != '0) && (count_q < BATCH_C);
    assign accept   = pep_if.in_vld && in_rdy;
    assign bcmd_vld = (state_q == ST_ISSUE) && (inflight_q < INFL_MAX);
    assign hs       = bcmd_vld && pep_if.bcmd_rdy;
    assign bdone_ok = pep_if.bdone && (inflight_q != '0);

    // Close is judged on the state as it will be after this cycle's accept.
    assign count_post = count_q + C_W'(accept);
    assign mask_post  = accept ? (mask_q | pid_onehot) : mask_q;
    assign timer_post = accept ? '0 : timer_q;
    assign close      = (count_post == BATCH_C) || empty_next || pep_if.flush
                     || ((TIMEOUT_CYCLES != 0) && (timer_post == TMR_LAST));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mask_d     = mask_q;
        timer_d    = '0;
        inflight_d = inflight_q + IF_W'(hs) - IF_W'(bdone_ok);
        case (state_q)
            ST_IDLE, ST_FILL: begin
                count_d = count_post;
                mask_d  = mask_post;
                if (count_post != '0) state_d = close ? ST_ISSUE : ST_FILL;
            end
            ST_ISSUE: begin
                if (hs) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    mask_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_q == ST_FILL) && (state_d == ST_FILL) && !accept && (timer_q != '1)) begin
            timer_d = timer_q + 1'b1;
        end else if ((state_q == ST_FILL) && (state_d == ST_FILL) && !accept) begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            mask_q     <= '0;
            timer_q    <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mask_q     <= mask_d;
            timer_q    <= timer_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst && pep_if.bdone) begin
            assert (inflight_q != '0) else $error("batch former: bdone with no batch in flight");
        end
    end

    assign pep_if.in_rdy        = in_rdy;
    assign pep_if.in_pid        = alloc_pid;
    assign pep_if.bcmd_vld      = bcmd_vld;
    assign pep_if.bcmd_pid_mask = mask_q;
    assign pep_if.bcmd_pbs_nb   = count_q;

endmodule

// File: tb/tb_pep_batch_former.sv
// Scoreboard bench for pep_batch_former: expected pids and batches queued at stimulus, checked at output.
module tb_pep_batch_former;

    typedef struct {
        int mask;
        int nb;
    } batch_t;

    logic clk = 1'b0;
    logic s_rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pid_q[$];
    batch_t bq[$];

    always #5 clk = ~clk;

    pep_batch_former_if pep_if ();

    pep_batch_former dut (
        .clk    (clk),
        .s_rst  (s_rst),
        .pep_if (pep_if)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    always @(negedge clk) begin
        if (!s_rst && pep_if.in_vld && pep_if.in_rdy) begin
            if (pid_q.size() == 0) chk("pid_unexpected", 1, 0);
            else chk("in_pid", int'(pep_if.in_pid), pid_q.pop_front());
        end
        if (!s_rst && pep_if.bcmd_vld && pep_if.bcmd_rdy) begin
            if (bq.size() == 0) begin
                chk("bcmd_unexpected", 1, 0);
            end else begin
                batch_t e;
                e = bq.pop_front();
                chk("bcmd_mask", int'(pep_if.bcmd_pid_mask), e.mask);
                chk("bcmd_pbs_nb", int'(pep_if.bcmd_pbs_nb), e.nb);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        pep_if.in_vld = 1'b0;
        pep_if.flush = 1'b0;
        pep_if.bdone = 1'b0;
        pep_if.free_vld = 1'b0;
        pep_if.free_pid = '0;
        pep_if.bcmd_rdy = 1'b1;
        repeat (2) step();
        pid_q.delete();
        bq.delete();
        s_rst = 1'b0;
    endtask

    task automatic req(input int exp_pid);
        int n;
        n = 0;
        pid_q.push_back(exp_pid);
        pep_if.in_vld = 1'b1;
        @(negedge clk);
        while (!pep_if.in_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("req_timeout", n, 0);
            void'(pid_q.pop_back());
        end
        step();
        pep_if.in_vld = 1'b0;
    endtask

    task automatic push_batch(input int mask, input int nb);
        batch_t b;
        b.mask = mask;
        b.nb = nb;
        bq.push_back(b);
    endtask

    task automatic wait_batches();
        int n;
        n = 0;
        while (bq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bq.size() != 0) begin
            chk("batch_timeout", bq.size(), 0);
            bq.delete();
        end
        step();
    endtask

    task automatic pulse_bdone();
        pep_if.bdone = 1'b1;
        step();
        pep_if.bdone = 1'b0;
    endtask

    task automatic pulse_flush();
        pep_if.flush = 1'b1;
        step();
        pep_if.flush = 1'b0;
    endtask

    task automatic free_one(input int pid);
        pep_if.free_vld = 1'b1;
        pep_if.free_pid = 5'(pid);
        step();
        pep_if.free_vld = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_rdy"}, int'(pep_if.in_rdy), 1);
        chk({tag, "_bcmd_vld"}, int'(pep_if.bcmd_vld), 0);
        chk({tag, "_mask"}, int'(pep_if.bcmd_pid_mask), 0);
        chk({tag, "_pbs_nb"}, int'(pep_if.bcmd_pbs_nb), 0);
        chk({tag, "_free_cnt"}, int'(pep_if.free_cnt), 32);
    endtask

    initial begin
        int n;
        do_reset();
        check_reset_outputs("reset");
        step();

        // Full batch of 16, in_rdy low while waiting in ISSUE.
        push_batch(32'h0000FFFF, 16);
        for (int i = 0; i < 16; i++) req(i);
        @(negedge clk);
        chk("full_issue_in_rdy", int'(pep_if.in_rdy), 0);
        chk("full_issue_vld", int'(pep_if.bcmd_vld), 1);
        wait_batches();
        pulse_bdone();

        // Partial batch closed by timeout.
        do_reset();
        push_batch(32'h7, 3);
        for (int i = 0; i < 3; i++) req(i);
        n = 0;
        @(negedge clk);
        while (!pep_if.bcmd_vld && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_idle_cycles", n, 64);
        wait_batches();
        pulse_bdone();

        // All 32 pids without frees; second batch waits for bdone.
        do_reset();
        push_batch(32'h0000FFFF, 16);
        push_batch(32'hFFFF0000, 16);
        for (int i = 0; i < 32; i++) req(i);
        repeat (3) @(negedge clk);
        chk("inflight_block_vld", int'(pep_if.bcmd_vld), 0);
        chk("exhaust_in_rdy", int'(pep_if.in_rdy), 0);
        chk("exhaust_free_cnt", int'(pep_if.free_cnt), 0);
        chk("second_batch_pending", bq.size(), 1);
        step();
        pulse_bdone();
        wait_batches();
        @(negedge clk);
        chk("empty_pool_idle_in_rdy", int'(pep_if.in_rdy), 0);
        step();
        pulse_bdone();

        // Recycled pid is reused; accept with simultaneous free holds free_cnt.
        free_one(5);
        push_batch(32'h20, 1);
        req(5);
        wait_batches();
        pulse_bdone();
        free_one(9);
        pep_if.free_vld = 1'b1;
        pep_if.free_pid = 5'd10;
        req(9);
        pep_if.free_vld = 1'b0;
        @(negedge clk);
        chk("accept_free_cnt", int'(pep_if.free_cnt), 1);
        chk("accept_free_vld", int'(pep_if.bcmd_vld), 0);
        step();
        push_batch(32'h200, 1);
        pulse_flush();
        wait_batches();
        pulse_bdone();

        // Flush closes a 2-pid batch; flush on an empty batch does nothing.
        do_reset();
        push_batch(32'h3, 2);
        req(0);
        req(1);
        pulse_flush();
        wait_batches();
        pulse_bdone();
        pulse_flush();
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (pep_if.bcmd_vld) n++;
        end
        chk("empty_flush_vld_cycles", n, 0);
        step();

        // Stalled bcmd_rdy keeps the command stable.
        do_reset();
        pep_if.bcmd_rdy = 1'b0;
        for (int i = 0; i < 3; i++) req(i);
        pulse_flush();
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (!(pep_if.bcmd_vld && pep_if.bcmd_pid_mask == 32'h7 && pep_if.bcmd_pbs_nb == 5'd3)) n++;
        end
        chk("stall_unstable_cycles", n, 0);
        step();
        push_batch(32'h7, 3);
        pep_if.bcmd_rdy = 1'b1;
        wait_batches();
        pulse_bdone();

        // Reset in the middle of filling discards the batch.
        do_reset();
        req(0);
        req(1);
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        check_reset_outputs("midfill_reset");
        step();
        req(0);
        @(negedge clk);
        chk("post_reset_pbs_nb", int'(pep_if.bcmd_pbs_nb), 1);
        step();

        chk("pid_queue_drained", pid_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "global timeout");
    end

endmodule
